pixel_sink_fb: RTL and testbench
================================

PIXEL_SINK_FB -- requirements
Module: pixel_sink_fb

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter COLOR_W, default 4, meaning pixel colour width in bits.
REQ-004 SHALL have parameter DEPTH, default 8, meaning pixel FIFO entries (power of two).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port pix_valid, input, 1, the rasterizer presents a pixel.
REQ-008 SHALL have port pix_x, input, 10, pixel column.
REQ-009 SHALL have port pix_y, input, 9, pixel row.
REQ-010 SHALL have port pix_color, input, COLOR_W, pixel colour.
REQ-011 SHALL have port pix_ready, output, 1, the block can accept a pixel this cycle.
REQ-012 SHALL have port clear_req, input, 1, a single-cycle pulse that requests a full-frame clear.
REQ-013 SHALL have port clear_color, input, COLOR_W, the fill colour, sampled in the cycle clear_req is high.
REQ-014 SHALL have port fb_we, output, 1, framebuffer write request.
REQ-015 SHALL have port fb_addr, output, 19, framebuffer word address.
REQ-016 SHALL have port fb_wdata, output, COLOR_W, framebuffer write data.
REQ-017 SHALL have port fb_ack, input, 1, the framebuffer accepts the current write this cycle.
REQ-018 SHALL have port busy, output, 1, work is pending or in progress.
REQ-019 SHALL have port drop_cnt, output, 16, count of clipped pixels.

Function
REQ-020 SHALL transfer a pixel on a posedge where pix_valid and pix_ready are both high; pix_valid with pix_ready low SHALL NOT transfer.
REQ-021 SHALL drive pix_ready = FIFO not full AND no clear pending AND state != CLEAR; there is no bypass, so a full FIFO SHALL refuse a push even in a cycle that pops.
REQ-022 SHALL accept a transferred pixel with pix_x >= H_RES or pix_y >= V_RES without enqueueing it, and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-023 SHALL enqueue an in-range pixel as {addr = pix_y*H_RES + pix_x (19-bit, unsigned), pix_color}.
REQ-024 SHALL have states IDLE, DRAIN and CLEAR, encoded in 2 bits.
REQ-025 In IDLE or DRAIN, SHALL drive fb_we = FIFO not empty and SHALL drive fb_addr and fb_wdata from the FIFO head; state SHALL be DRAIN whenever the FIFO is not empty.
REQ-026 SHALL pop the head on a posedge where fb_we and fb_ack are both high; fb_addr and fb_wdata SHALL be held stable while fb_we is high and fb_ack is low.
REQ-027 Latency: a pixel accepted into an empty FIFO at edge k SHALL present fb_we=1 in the cycle following edge k.
REQ-028 SHALL order writes strictly FIFO; pixel order SHALL be preserved.
REQ-029 SHALL latch clear_req and clear_color into clear_pending; a clear_req while clear_pending is set or in CLEAR SHALL be ignored.
REQ-030 With clear_pending set, SHALL enter CLEAR only once the FIFO is empty and no write is outstanding.
REQ-031 On entering CLEAR, SHALL clear clear_pending.
REQ-032 In CLEAR, SHALL drive fb_we=1 with fb_addr running from 0 to H_RES*V_RES-1, advancing only on fb_ack, and fb_wdata = latched clear_color.
REQ-033 The ack of address H_RES*V_RES-1 SHALL return the block to IDLE, with pix_ready re-asserting in the next cycle.
REQ-034 SHALL drive busy = (state != IDLE) OR FIFO not empty OR clear_pending.
REQ-035 When fb_we=0, fb_addr and fb_wdata SHALL be 0.

Reset
REQ-036 On a posedge with reset=0, SHALL empty the FIFO, set state to IDLE, clear clear_pending, and set drop_cnt=0, fb_we=0, fb_addr=0, fb_wdata=0.
REQ-037 While reset=0, SHALL hold pix_ready=0 and busy=0.
REQ-038 A reset during DRAIN or CLEAR SHALL abort immediately, with no further writes issued.

Verification
REQ-039 Reset, then push (5,2,c=3) with fb_ack tied high -> fb_we high one cycle later with fb_addr=1285, fb_wdata=3; busy falls after the ack.
REQ-040 Hold fb_ack=0 and push 9 pixels -> 8 accepted and pix_ready=0; release fb_ack -> 8 writes issued in push order.
REQ-041 Push (640,0) then (0,480) -> no fb_we asserted and drop_cnt=2.
REQ-042 Push 3 pixels, pulse clear_req with clear_color=7, fb_ack=1 -> the 3 pixel writes complete first, then 307200 writes of 7 at addresses 0..307199, with pix_ready=0 throughout.
REQ-043 Assert reset at clear address 1000 -> next cycle fb_we=0, state IDLE, pix_ready=1 after reset release.
REQ-044 Pulse fb_ack at random with pix_valid at random -> a scoreboard sees every in-range pixel written exactly once, in order.

Source files
------------

// File: rtl/pixel_sink_fb.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink_fb
// Purpose  : Accepts rasterizer pixels, clips off-screen ones, buffers the
//            rest in a small FIFO and writes them to a framebuffer in order.
//            On request it fills the whole frame with a single colour once
//            all previously accepted pixels have been written.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sink_fb #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 4,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [8:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               fb_we,
  output logic [18:0]        fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_ack,
  output logic               busy,
  output logic [15:0]        drop_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          ENTRY_W  = 19 + COLOR_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [10:0] H_LIM    = 11'(H_RES);
  localparam logic [9:0]  V_LIM    = 10'(V_RES);
  localparam logic [18:0] CLR_LAST = 19'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 clear_pending_q, clear_pending_d;
  logic [COLOR_W-1:0]   clear_color_q, clear_color_d;
  logic [18:0]          clr_addr_q, clr_addr_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 in_range;
  logic                 xfer;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic [ENTRY_W-1:0]   head;
  logic [18:0]          pix_addr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // No bypass path: a full FIFO refuses a push even when it pops this cycle.
  assign pix_ready  = reset && !fifo_full && !clear_pending_q && (state_q != ST_CLEAR);
  assign in_range   = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
  assign xfer       = pix_valid && pix_ready;
  assign push       = xfer && in_range;
  assign drop       = xfer && !in_range;
  assign pix_addr   = 19'(pix_y) * 19'(H_RES) + 19'(pix_x);

  assign head       = mem_q[rd_ptr_q];
  assign pop        = reset && (state_q != ST_CLEAR) && !fifo_empty && fb_ack;
  assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign busy       = reset && ((state_q != ST_IDLE) || !fifo_empty || clear_pending_q);
  assign drop_cnt   = drop_cnt_q;

  // Next-state, clear sequencing and framebuffer write port.
  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_color_d   = clear_color_q;
    clr_addr_d      = clr_addr_q;
    drop_cnt_d      = drop_cnt_q;
    fb_we           = 1'b0;
    fb_addr         = '0;
    fb_wdata        = '0;

    case (state_q)
      ST_CLEAR: begin
        fb_we    = 1'b1;
        fb_addr  = clr_addr_q;
        fb_wdata = clear_color_q;
        if (fb_ack) begin
          if (clr_addr_q == CLR_LAST) begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + 19'd1;
          end
        end
      end
      default: begin
        if (!fifo_empty) begin
          fb_we    = 1'b1;
          fb_addr  = head[ENTRY_W-1 -: 19];
          fb_wdata = head[COLOR_W-1:0];
        end
        // Pushes are blocked while a clear is pending, so an empty FIFO
        // here means every earlier pixel has been acknowledged.
        if (clear_pending_q && fifo_empty) begin
          state_d         = ST_CLEAR;
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
        end else if (count_d != '0) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (clear_req && !clear_pending_q && (state_q != ST_CLEAR)) begin
      clear_pending_d = 1'b1;
      clear_color_d   = clear_color;
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Nothing is written while reset is held.
    if (!reset) begin
      fb_we    = 1'b0;
      fb_addr  = '0;
      fb_wdata = '0;
    end
  end

  // State and clear/drop bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      clr_addr_q      <= '0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
      clr_addr_q      <= clr_addr_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; occupancy gates every read so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pix_addr, pix_color};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink_fb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sink_fb
// Purpose  : Self-checking bench for pixel_sink_fb using a queue-based model
//            of the expected framebuffer write stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink_fb;

  localparam int H_T  = 20;
  localparam int V_T  = 10;
  localparam int CW   = 4;
  localparam int DP   = 8;
  localparam int NPIX = H_T * V_T;

  logic          clk;
  logic          reset;
  logic          pix_valid;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic [CW-1:0] pix_color;
  logic          pix_ready;
  logic          clear_req;
  logic [CW-1:0] clear_color;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [CW-1:0] fb_wdata;
  logic          fb_ack;
  logic          busy;
  logic [15:0]   drop_cnt;

  pixel_sink_fb #(
    .H_RES   (H_T),
    .V_RES   (V_T),
    .COLOR_W (CW),
    .DEPTH   (DP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .pix_ready   (pix_ready),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .fb_ack      (fb_ack),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: writes still owed by the block, in the order they must appear.
  typedef struct {
    logic [18:0]   a;
    logic [CW-1:0] c;
    bit            clr;
  } ent_t;

  ent_t             pend_q[$];
  logic [18+CW:0]   obs_done[$];
  logic [18+CW:0]   exp_done[$];
  int               occ;
  int               clr_left;
  logic [15:0]      drop_m;
  int               ready_err, busy_err, hold_err, idle_err, extra_wr;
  logic             prev_stall;
  logic [18:0]      prev_addr;
  logic [CW-1:0]    prev_data;
  int               total, bad;

  // Advance one clock, updating the model from the handshakes of this cycle.
  task automatic step();
    ent_t e;
    logic exp_ready, exp_busy, clr_idle;
    #1;
    if (!reset) begin
      if (pix_ready !== 1'b0) ready_err++;
      if (busy !== 1'b0) busy_err++;
      pend_q.delete();
      occ = 0; clr_left = 0; drop_m = 16'd0; prev_stall = 1'b0;
    end else begin
      clr_idle  = (clr_left == 0);
      exp_ready = (occ < DP) && clr_idle;
      exp_busy  = (occ > 0) || !clr_idle;
      if (pix_ready !== exp_ready) ready_err++;
      if (busy !== exp_busy) busy_err++;
      if (fb_we !== 1'b1 && (fb_addr !== 19'd0 || fb_wdata !== '0)) idle_err++;
      if (prev_stall && (fb_we !== 1'b1 || fb_addr !== prev_addr || fb_wdata !== prev_data)) hold_err++;
      prev_stall = (fb_we === 1'b1) && (fb_ack === 1'b0);
      prev_addr  = fb_addr;
      prev_data  = fb_wdata;
      if (fb_we === 1'b1 && fb_ack === 1'b1) begin
        obs_done.push_back({fb_addr, fb_wdata});
        if (pend_q.size() == 0) begin
          extra_wr++;
        end else begin
          e = pend_q.pop_front();
          exp_done.push_back({e.a, e.c});
          if (e.clr) clr_left--; else occ--;
        end
      end
      if (pix_valid && exp_ready) begin
        if (int'(pix_x) < H_T && int'(pix_y) < V_T) begin
          pend_q.push_back('{a: 19'(int'(pix_y) * H_T + int'(pix_x)), c: pix_color, clr: 1'b0});
          occ++;
        end else if (drop_m != 16'hFFFF) begin
          drop_m++;
        end
      end
      if (clear_req && clr_idle) begin
        for (int i = 0; i < NPIX; i++) pend_q.push_back('{a: 19'(i), c: clear_color, clr: 1'b1});
        clr_left = NPIX;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++;
    if (fb_we !== 1'b0 || fb_addr !== 19'd0 || fb_wdata !== '0) begin
      bad++; $display("FAIL reset_fb: we=%0b addr=%0d data=%0d, required 0/0/0", fb_we, fb_addr, fb_wdata);
    end
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt);
    end
    reset = 1'b1;
    #1;
    total++;
    if (pix_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: ready=%0b busy=%0b, required 1/0", pix_ready, busy);
    end
    step();
  endtask

  task automatic test_single();
    obs_done.delete(); exp_done.delete();
    fb_ack = 1'b1;
    pix_valid = 1'b1; pix_x = 10'd5; pix_y = 9'd2; pix_color = 4'd3;
    step();
    pix_valid = 1'b0;
    #1;
    total++;
    if (fb_we !== 1'b1 || fb_addr !== 19'(2 * H_T + 5) || fb_wdata !== 4'd3) begin
      bad++; $display("FAIL single_latency: we=%0b addr=%0d data=%0d, required 1/%0d/3", fb_we, fb_addr, fb_wdata, 2 * H_T + 5);
    end
    step();
    total++;
    if (busy !== 1'b0 || fb_we !== 1'b0) begin
      bad++; $display("FAIL single_done: busy=%0b we=%0b, required 0/0", busy, fb_we);
    end
    total++;
    if (obs_done.size() != 1) begin
      bad++; $display("FAIL single_count: got %0d writes, required 1", obs_done.size());
    end
  endtask

  task automatic test_backpressure();
    int nb;
    obs_done.delete(); exp_done.delete();
    fb_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pix_valid = 1'b1; pix_x = 10'(i + 1); pix_y = 9'(i % V_T); pix_color = 4'(i + 2);
      step();
    end
    pix_valid = 1'b0;
    #1;
    total++;
    if (pix_ready !== 1'b0 || fb_addr !== 19'd1) begin
      bad++; $display("FAIL bp_full: ready=%0b head_addr=%0d, required 0/1", pix_ready, fb_addr);
    end
    fb_ack = 1'b1;
    for (int i = 0; i < 12; i++) step();
    nb = 0;
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      if (obs_done[i] !== exp_done[i]) nb++;
    total++;
    if (obs_done.size() != 8 || nb != 0) begin
      bad++; $display("FAIL bp_order: %0d writes with %0d out of order, required 8 with 0", obs_done.size(), nb);
    end
    total++;
    if (ready_err + busy_err + hold_err + idle_err + extra_wr != 0) begin
      bad++; $display("FAIL bp_proto: ready=%0d busy=%0d hold=%0d idle=%0d extra=%0d, required all 0", ready_err, busy_err, hold_err, idle_err, extra_wr);
    end
    ready_err = 0; busy_err = 0; hold_err = 0; idle_err = 0; extra_wr = 0;
  endtask

  task automatic test_clip();
    obs_done.delete(); exp_done.delete();
    fb_ack = 1'b1;
    pix_valid = 1'b1; pix_x = 10'(H_T); pix_y = 9'd0; pix_color = 4'd1;
    step();
    pix_x = 10'd0; pix_y = 9'(V_T);
    step();
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (obs_done.size() != 0) begin
      bad++; $display("FAIL clip_nowrite: got %0d writes, required 0", obs_done.size());
    end
    total++;
    if (drop_cnt !== 16'd2) begin
      bad++; $display("FAIL clip_drop: got %0d, required 2", drop_cnt);
    end
    pix_valid = 1'b1; pix_x = 10'(H_T - 1); pix_y = 9'(V_T - 1); pix_color = 4'd9;
    step();
    pix_valid = 1'b0;
    #1;
    total++;
    if (fb_we !== 1'b1 || fb_addr !== 19'(NPIX - 1) || fb_wdata !== 4'd9) begin
      bad++; $display("FAIL clip_corner: we=%0b addr=%0d data=%0d, required 1/%0d/9", fb_we, fb_addr, fb_wdata, NPIX - 1);
    end
    step();
  endtask

  task automatic test_clear();
    int nb, n;
    obs_done.delete(); exp_done.delete();
    fb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_x = 10'(i + 3); pix_y = 9'd1; pix_color = 4'(i + 1);
      clear_req = (i == 2); clear_color = 4'd7;
      step();
    end
    clear_req = 1'b0;
    pix_x = 10'd1; pix_y = 9'd1;
    for (int i = 0; i < 20; i++) begin
      clear_req = (i == 10); clear_color = 4'd5;
      step();
    end
    clear_req = 1'b0; pix_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < NPIX + 50) begin step(); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clear_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
    step();
    nb = 0;
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      if (obs_done[i] !== exp_done[i]) nb++;
    total++;
    if (obs_done.size() != 3 + NPIX || nb != 0) begin
      bad++; $display("FAIL clear_stream: %0d writes with %0d wrong, required %0d with 0", obs_done.size(), nb, 3 + NPIX);
    end
    total++;
    if (obs_done.size() == 3 + NPIX && (obs_done[3] !== {19'd0, 4'd7} || obs_done[2 + NPIX] !== {19'(NPIX - 1), 4'd7})) begin
      bad++; $display("FAIL clear_ends: first=%h last=%h, required %h/%h", obs_done[3], obs_done[2 + NPIX], {19'd0, 4'd7}, {19'(NPIX - 1), 4'd7});
    end
    total++;
    if (ready_err + busy_err + hold_err + idle_err + extra_wr != 0) begin
      bad++; $display("FAIL clear_proto: ready=%0d busy=%0d hold=%0d idle=%0d extra=%0d, required all 0", ready_err, busy_err, hold_err, idle_err, extra_wr);
    end
    ready_err = 0; busy_err = 0; hold_err = 0; idle_err = 0; extra_wr = 0;
  endtask

  task automatic test_reset_abort();
    int n, nwr;
    obs_done.delete(); exp_done.delete();
    fb_ack = 1'b1;
    clear_req = 1'b1; clear_color = 4'hA;
    step();
    clear_req = 1'b0;
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr === 19'd100) && n < NPIX + 20) begin step(); n++; end
    total++;
    if (!(fb_we === 1'b1 && fb_addr === 19'd100)) begin
      bad++; $display("FAIL abort_reach: addr=%0d we=%0b, required clear at 100", fb_addr, fb_we);
    end
    nwr = obs_done.size();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++;
    if (fb_we !== 1'b0 || fb_addr !== 19'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_stop: we=%0b addr=%0d busy=%0b, required 0/0/0", fb_we, fb_addr, busy);
    end
    total++;
    if (pix_ready !== 1'b1) begin
      bad++; $display("FAIL abort_ready: got %0b, required 1", pix_ready);
    end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (obs_done.size() != nwr || nwr != 100) begin
      bad++; $display("FAIL abort_writes: %0d before, %0d after, required 100 and no more", nwr, obs_done.size());
    end
  endtask

  task automatic test_random();
    int nb, n;
    obs_done.delete(); exp_done.delete();
    for (int i = 0; i < 400; i++) begin
      pix_valid = 1'($urandom % 2);
      pix_x     = 10'($urandom_range(H_T + 2, 0));
      pix_y     = 9'($urandom_range(V_T + 1, 0));
      pix_color = 4'($urandom);
      fb_ack    = 1'($urandom % 2);
      step();
    end
    pix_valid = 1'b0; fb_ack = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin step(); n++; end
    step();
    nb = 0;
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      if (obs_done[i] !== exp_done[i]) nb++;
    total++;
    if (obs_done.size() != exp_done.size() || pend_q.size() != 0 || nb != 0) begin
      bad++; $display("FAIL rand_order: %0d written, %0d expected, %0d owed, %0d wrong; required all owed written in order", obs_done.size(), exp_done.size(), pend_q.size(), nb);
    end
    total++;
    if (drop_cnt !== drop_m) begin
      bad++; $display("FAIL rand_drop: got %0d, required %0d", drop_cnt, drop_m);
    end
    total++;
    if (ready_err + busy_err + hold_err + idle_err + extra_wr != 0) begin
      bad++; $display("FAIL rand_proto: ready=%0d busy=%0d hold=%0d idle=%0d extra=%0d, required all 0", ready_err, busy_err, hold_err, idle_err, extra_wr);
    end
    ready_err = 0; busy_err = 0; hold_err = 0; idle_err = 0; extra_wr = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    occ = 0; clr_left = 0; drop_m = 16'd0;
    ready_err = 0; busy_err = 0; hold_err = 0; idle_err = 0; extra_wr = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    reset = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_req = 1'b0; clear_color = '0; fb_ack = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_clip();
    test_clear();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
